// File: rtl/divider8x4.sv
// Sequential restoring divider, DW-bit dividend / VW-bit divisor -> DW-bit quotient, VW-bit remainder.
// Latency: ready rises DW+1 edges after the edge that samples start=0 in LOAD; start/ready level handshake, no backpressure.
// Optional DIV_ZERO_FLAG_EN adds a dz output flagging a latched divisor of zero.
module divider8x4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    input  logic          start,
    output logic          ready,
    output logic [DW-1:0] quo,
    output logic [VW-1:0] rem
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic          dz
`endif
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   dvd;
    logic [VW-1:0]   bsr;
    logic [VW-1:0]   part;
    logic [VW:0]     shifted;
    logic            sub_ok;

    // Partial remainder after each step is < B, so VW bits hold it; the
    // extra bit only lives in the shifted trial value.
    assign shifted = {part, dvd[DW-1]};
    assign sub_ok  = (shifted >= {1'b0, bsr});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (!start) state_nxt = CALC;
            CALC:    if (cnt == CW'(DW - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            dvd   <= '0;
            bsr   <= '0;
            part  <= '0;
            ready <= 1'b0;
            quo   <= '0;
            rem   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= A;
                        bsr   <= B;
                        ready <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                        dz    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (start) begin
                        dvd <= A;
                        bsr <= B;
                    end else begin
                        part <= '0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    // Quotient bits enter at the bottom as dividend bits leave the top.
                    part <= sub_ok ? VW'(shifted - {1'b0, bsr}) : shifted[VW-1:0];
                    dvd  <= {dvd[DW-2:0], sub_ok};
                    cnt  <= cnt + 1'b1;
                end
                DONE: begin
                    quo   <= dvd;
                    rem   <= (bsr == '0) ? '0 : part;
                    ready <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    dz    <= (bsr == '0);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider8x4.sv
// Randomized bench for divider8x4: per-cycle comparison against an arithmetic model of ready/quo/rem.
module tb_divider8x4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [3:0] B;
    logic       start;
    logic       ready;
    logic [7:0] quo;
    logic [3:0] rem;
`ifdef DIV_ZERO_FLAG_EN
    logic       dz;
`endif

    divider8x4 dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .start (start),
        .ready (ready),
        .quo   (quo),
        .rem   (rem)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .dz    (dz)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the outputs must show right now.
    logic       exp_ready = 1'b0;
    logic [7:0] exp_quo   = 8'd0;
    logic [3:0] exp_rem   = 4'd0;
    logic       exp_dz    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(exp_ready));
        chk("quo", 32'(quo), 32'(exp_quo));
        chk("rem", 32'(rem), 32'(exp_rem));
`ifdef DIV_ZERO_FLAG_EN
        chk("dz", 32'(dz), 32'(exp_dz));
`endif
    end

    // Called at posedge+1. Operands a0/b0 are presented on all but the last
    // start-high cycle and must be discarded; a/b is the operand pair that counts.
    task automatic op(input logic [7:0] a0, input logic [3:0] b0,
                      input logic [7:0] a, input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                A = a;
                B = b;
            end else begin
                A = a0;
                B = b0;
            end
            start = 1'b1;
            @(posedge clk);
            #1;
            if (i == 0) begin
                exp_ready = 1'b0;
                exp_dz    = 1'b0;
            end
        end
        start = 1'b0;
        A = 8'($urandom);
        B = 4'($urandom);
        // First edge samples start=0; ready appears on the ninth edge after it.
        repeat (10) @(posedge clk);
        #1;
        exp_ready = 1'b1;
        if (b == 4'd0) begin
            exp_quo = 8'hFF;
            exp_rem = 4'd0;
            exp_dz  = 1'b1;
        end else begin
            exp_quo = a / b;
            exp_rem = a % b;
            exp_dz  = 1'b0;
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        A     = 8'd0;
        B     = 4'd0;
        #50;
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;

        // Basic operation with literal expectations.
        op(8'd143, 4'd12, 8'd143, 4'd12, 2);
        chk("lit_143_12_quo", 32'(quo), 32'd11);
        chk("lit_143_12_rem", 32'(rem), 32'd11);
        repeat (5) @(posedge clk);
        #1;

        // Divide by zero, then a normal op that must clear the zero indication.
        op(8'd200, 4'd0, 8'd200, 4'd0, 1);
        chk("lit_dz_quo", 32'(quo), 32'd255);
        chk("lit_dz_rem", 32'(rem), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("lit_dz_flag", 32'(dz), 32'd1);
`endif
        op(8'd6, 4'd3, 8'd6, 4'd3, 1);
        chk("lit_6_3_quo", 32'(quo), 32'd2);
        chk("lit_6_3_rem", 32'(rem), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("lit_6_3_dz", 32'(dz), 32'd0);
`endif

        // Operands change while start is held; the last pair wins.
        op(8'd50, 4'd7, 8'd225, 4'd15, 3);
        chk("lit_hold_quo", 32'(quo), 32'd15);
        chk("lit_hold_rem", 32'(rem), 32'd0);

        // Reset four cycles into CALC.
        A = 8'd99;
        B = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_ready = 1'b0;
        exp_dz    = 1'b0;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_ready = 1'b0;
        exp_quo   = 8'd0;
        exp_rem   = 4'd0;
        exp_dz    = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_quo", 32'(quo), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        op(8'd99, 4'd5, 8'd99, 4'd5, 1);
        chk("lit_99_5_quo", 32'(quo), 32'd19);
        chk("lit_99_5_rem", 32'(rem), 32'd4);

        // Exhaustive sweep with random hold lengths, discarded operands and gaps.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                op(8'($urandom), 4'($urandom), 8'(a), 4'(b), 1 + int'($urandom_range(1)));
                chk("inv_sum", int'(quo) * b + int'(rem), 32'(a));
                chk("inv_rem_lt_b", 32'(int'(rem) < b), 32'd1);
                if ($urandom_range(1) == 1) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
